// File: rtl/gsim_x_collector_if.sv
// Solver-to-collector word stream plus the collector's valid/ready output stream.
interface gsim_x_collector_if #(
  parameter int IDX_W = 4
);
  logic             x_valid;
  logic [31:0]      x_in;
  logic             o_ready;
  logic             o_valid;
  logic [15:0]      o_data;
  logic [IDX_W-1:0] o_idx;
  logic             o_last;

  modport master (
    output x_valid, x_in, o_ready,
    input  o_valid, o_data, o_idx, o_last
  );

  modport slave (
    input  x_valid, x_in, o_ready,
    output o_valid, o_data, o_idx, o_last
  );
endinterface

// File: rtl/gsim_x_collector.sv
// Buffers one Q16.16 solver frame as rounded int16 and drains it over valid/ready; o_valid rises the
// cycle after the last word is stored, holds under backpressure. GSIM_COLLECT_CHECKSUM_EN appends a sum beat.
module gsim_x_collector #(
  parameter int N_VAR = 16,
  parameter int IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  gsim_x_collector_if.slave    bus,
  output logic                 busy,
  output logic                 overflow
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VAR - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  logic [1:0]       state;
  logic [IDX_W-1:0] wcnt;
  logic [IDX_W-1:0] rcnt;
  logic [15:0]      frame_q [N_VAR];

  logic signed [32:0] t;
  logic signed [16:0] q;
  logic [15:0]        x_rnd;
  logic               drain;
  logic               wr_en;
  logic               xfer;
  logic               last_beat;
  logic               adv;
  logic [15:0]        beat_data;

  // Round half up, then clamp the 17-bit quotient into int16 range.
  always_comb begin
    t = $signed({bus.x_in[31], bus.x_in}) + 33'sh0_0000_8000;
    q = 17'(t >>> 16);
    if (!q[16] && q[15]) begin
      x_rnd = 16'h7fff;
    end else if (q[16] && !q[15]) begin
      x_rnd = 16'h8000;
    end else begin
      x_rnd = q[15:0];
    end
  end

  assign drain = (state == S_DRAIN);
  assign wr_en = bus.x_valid && !drain;
  assign xfer  = drain && bus.o_ready;
  assign busy  = (state != S_IDLE);

`ifdef GSIM_COLLECT_CHECKSUM_EN
  logic [15:0] csum;
  logic        csum_beat;

  assign last_beat = csum_beat;
  // rcnt parks on the final index while the checksum beat goes out.
  assign adv       = (rcnt != LAST_IDX);
  assign beat_data = csum_beat ? csum : frame_q[rcnt];

  always_ff @(posedge clk) begin
    if (reset) begin
      csum      <= '0;
      csum_beat <= 1'b0;
    end else begin
      if (wr_en) begin
        csum <= (state == S_IDLE) ? x_rnd : csum + x_rnd;
      end
      if (xfer) begin
        csum_beat <= (rcnt == LAST_IDX) && !csum_beat;
      end
    end
  end
`else
  assign last_beat = (rcnt == LAST_IDX);
  assign adv       = 1'b1;
  assign beat_data = frame_q[rcnt];
`endif

  assign bus.o_valid = drain;
  assign bus.o_idx   = rcnt;
  assign bus.o_data  = drain ? beat_data : 16'h0000;
  assign bus.o_last  = drain && last_beat;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      frame_q[wcnt] <= x_rnd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      rcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.x_valid) begin
            state <= S_COLLECT;
            wcnt  <= ONE;
          end
        end
        S_COLLECT: begin
          if (bus.x_valid) begin
            if (wcnt == LAST_IDX) begin
              state <= S_DRAIN;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt + ONE;
            end
          end
        end
        S_DRAIN: begin
          // Words arriving now are dropped; only the sticky flag records them.
          if (bus.x_valid) begin
            overflow <= 1'b1;
          end
          if (bus.o_ready) begin
            if (last_beat) begin
              state <= S_IDLE;
              rcnt  <= '0;
            end else if (adv) begin
              rcnt <= rcnt + ONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gsim_x_collector.sv
// Table- and scoreboard-driven bench for gsim_x_collector; checksum beats expected when GSIM_COLLECT_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_gsim_x_collector;
  localparam int N_VAR = 16;
  localparam int IDX_W = 4;
`ifdef GSIM_COLLECT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct {
    logic [31:0] x;
    logic [15:0] e;
  } vec_t;

  typedef struct {
    logic [15:0]      data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic overflow;

  gsim_x_collector_if #(.IDX_W(IDX_W)) bus();

  gsim_x_collector #(.N_VAR(N_VAR), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  beat_t sb[$];
  vec_t  fr[N_VAR];
  vec_t  conv_tbl[N_VAR];
  int    n_checks = 0;
  int    n_errors = 0;
  int    ready_mode = 0;
  bit    idle_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Beats are checked against the queue head on every valid cycle, stalled or not.
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      idle_chk = 1'b0;
    end else begin
      if (idle_chk) begin
        check("idle_busy", busy, 0);
        check("idle_valid", bus.o_valid, 0);
        idle_chk = 1'b0;
      end
      if (bus.o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          check("beat_data", bus.o_data, sb[0].data);
          check("beat_idx", bus.o_idx, sb[0].idx);
          check("beat_last", bus.o_last, sb[0].last);
          if (bus.o_ready === 1'b1) begin
            if (sb[0].last) idle_chk = 1'b1;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) begin
        bus.o_ready = (ph % 4 == 0) || (ph % 4 == 3);
        ph++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.x_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_o_data", bus.o_data, 0);
    check("rst_o_idx", bus.o_idx, 0);
    check("rst_o_last", bus.o_last, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    sb.delete();
    reset = 1'b0;
  endtask

  task automatic send_frame(input bit push, input bit gaps, input bit chk_lat);
    beat_t b;
    logic [15:0] sum;
    sum = 16'h0000;
    @(posedge clk);
    #1;
    for (int k = 0; k < N_VAR; k++) begin
      bus.x_valid = 1'b1;
      bus.x_in = fr[k].x;
      if (push) begin
        b.data = fr[k].e;
        b.idx  = IDX_W'(k);
        b.last = (k == N_VAR - 1) && !CSUM;
        sb.push_back(b);
        sum = sum + fr[k].e;
      end
      if (chk_lat) begin
        @(negedge clk);
        if (k == 0) check("busy_before_first", busy, 0);
        if (k == N_VAR - 1) begin
          check("valid_before_last_store", bus.o_valid, 0);
          check("busy_collect", busy, 1);
        end
      end
      @(posedge clk);
      #1;
      if (gaps && (k % 4 == 1)) begin
        bus.x_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.x_valid = 1'b0;
    if (push && CSUM) begin
      b.data = sum;
      b.idx  = IDX_W'(N_VAR - 1);
      b.last = 1'b1;
      sb.push_back(b);
    end
    if (chk_lat) begin
      @(negedge clk);
      check("valid_cycle17", bus.o_valid, 1);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || busy !== 1'b0) && n < 300);
    if (sb.size() != 0 || busy !== 1'b0) fail(name);
  endtask

  task automatic setv(input int i, input logic [31:0] x, input logic [15:0] e);
    conv_tbl[i].x = x;
    conv_tbl[i].e = e;
  endtask

  initial begin
    int n;
    bus.x_valid = 1'b0;
    bus.x_in    = 32'h0;
    bus.o_ready = 1'b1;

    setv(0,  32'h00018000, 16'h0002);
    setv(1,  32'hFFFE8000, 16'hFFFF);
    setv(2,  32'h00017FFF, 16'h0001);
    setv(3,  32'h7FFF8000, 16'h7FFF);
    setv(4,  32'h80000000, 16'h8000);
    setv(5,  32'h00000000, 16'h0000);
    setv(6,  32'h00008000, 16'h0001);
    setv(7,  32'hFFFF8000, 16'h0000);
    setv(8,  32'hFFFF7FFF, 16'hFFFF);
    setv(9,  32'h7FFF7FFF, 16'h7FFF);
    setv(10, 32'h80007FFF, 16'h8000);
    setv(11, 32'hC0000000, 16'hC000);
    setv(12, 32'h3FFF8000, 16'h4000);
    setv(13, 32'h00007FFF, 16'h0000);
    setv(14, 32'hFFFFFFFF, 16'h0000);
    setv(15, 32'h12345678, 16'h1234);

    do_reset();

    // Contiguous ramp with latency check.
    for (int k = 0; k < N_VAR; k++) begin
      fr[k].x = 32'(k) << 16;
      fr[k].e = 16'(k);
    end
    send_frame(1'b1, 1'b0, 1'b1);
    wait_idle("ramp_drain");

    // Rounding/saturation table, with input gaps.
    for (int k = 0; k < N_VAR; k++) fr[k] = conv_tbl[k];
    send_frame(1'b1, 1'b1, 1'b0);
    wait_idle("table_drain");

    // Backpressure 1,0,0,1.
    for (int k = 0; k < N_VAR; k++) begin
      fr[k].x = 32'(k * 3 - 7) << 16;
      fr[k].e = 16'(k * 3 - 7);
    end
    ready_mode = 1;
    send_frame(1'b1, 1'b0, 1'b0);
    wait_idle("bp_drain");
    ready_mode = 0;
    bus.o_ready = 1'b1;
    check("ovf_still_clear", overflow, 0);

    // Word arriving in the same cycle as the final transfer.
    for (int k = 0; k < N_VAR; k++) begin
      fr[k].x = 32'(k + 40) << 16;
      fr[k].e = 16'(k + 40);
    end
    send_frame(1'b1, 1'b0, 1'b0);
    n = 0;
    while (!(bus.o_valid === 1'b1 && bus.o_last === 1'b1 && bus.o_ready === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("last_beat_timeout");
    bus.x_valid = 1'b1;
    bus.x_in = 32'h00090000;
    @(posedge clk);
    #1;
    bus.x_valid = 1'b0;
    @(negedge clk);
    check("ovf_last_xfer", overflow, 1);
    repeat (3) @(negedge clk);
    check("no_new_frame_busy", busy, 0);

    // Reset in the middle of COLLECT.
    @(posedge clk);
    #1;
    for (int k = 0; k < 7; k++) begin
      bus.x_valid = 1'b1;
      bus.x_in = 32'h00030000;
      @(posedge clk);
      #1;
    end
    bus.x_valid = 1'b0;
    check("busy_mid_collect", busy, 1);
    do_reset();
    for (int k = 0; k < N_VAR; k++) begin
      fr[k].x = 32'h00050000;
      fr[k].e = 16'd5;
    end
    send_frame(1'b1, 1'b0, 1'b1);
    wait_idle("fives_drain");
    check("ovf_after_reset", overflow, 0);

    // New burst while 10 beats remain undrained.
    for (int k = 0; k < N_VAR; k++) begin
      fr[k].x = 32'(100 + k) << 16;
      fr[k].e = 16'(100 + k);
    end
    bus.o_ready = 1'b0;
    send_frame(1'b1, 1'b0, 1'b0);
    bus.o_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.o_ready = 1'b0;
    check("sb_remaining", sb.size(), 10 + (CSUM ? 1 : 0));
    for (int k = 0; k < N_VAR; k++) begin
      fr[k].x = 32'(200 + k) << 16;
      fr[k].e = 16'(200 + k);
    end
    send_frame(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_collision", overflow, 1);
    bus.o_ready = 1'b1;
    wait_idle("collision_drain");
    repeat (3) @(negedge clk);
    check("no_second_frame", bus.o_valid, 0);

`ifdef GSIM_COLLECT_CHECKSUM_EN
    do_reset();
    for (int k = 0; k < N_VAR; k++) begin
      fr[k].x = 32'h00010000;
      fr[k].e = 16'd1;
    end
    send_frame(1'b1, 1'b0, 1'b0);
    check("csum_ones", sb[sb.size()-1].data, 16'd16);
    wait_idle("csum_ones_drain");
    for (int k = 0; k < N_VAR; k++) begin
      fr[k].x = 32'h7FFF0000;
      fr[k].e = 16'h7FFF;
    end
    send_frame(1'b1, 1'b0, 1'b0);
    check("csum_max", sb[sb.size()-1].data, 16'hFFF0);
    wait_idle("csum_max_drain");
`endif

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
